// File: rtl/moore_overlap_seq_detector.sv
// rtl/moore_overlap_seq_detector.sv - Moore FSM detecting overlapping 1-0-0-1 on a serial bit stream
// Optional saturating match counter enabled by defining MOORE_OVER_COUNT_EN.
module moore_overlap_seq_detector
`ifdef MOORE_OVER_COUNT_EN
  #(parameter int COUNT_W = 8)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic detector
`ifdef MOORE_OVER_COUNT_EN
  , output logic [COUNT_W-1:0] match_count
`endif
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state;

  // S4 exits exactly like S1 so the trailing 1 of a match seeds the next one.
  function automatic state_t next_of(input state_t cur, input logic bit_in);
    state_t nxt;
    nxt = S0;
    case (cur)
      S0:      nxt = bit_in ? S1 : S0;
      S1:      nxt = bit_in ? S1 : S2;
      S2:      nxt = bit_in ? S1 : S3;
      S3:      nxt = bit_in ? S4 : S0;
      S4:      nxt = bit_in ? S1 : S2;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  state_t state_nxt;
  assign state_nxt = next_of(state, data);

  // detector is registered alongside state, so it always equals (state == S4).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S0;
      detector <= 1'b0;
    end else begin
      state    <= state_nxt;
      detector <= (state_nxt == S4);
    end
  end

`ifdef MOORE_OVER_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
    end else if (state_nxt == S4 && match_count != {COUNT_W{1'b1}}) begin
      match_count <= match_count + COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_moore_overlap_seq_detector.sv
// tb/tb_moore_overlap_seq_detector.sv - scoreboard bench for moore_overlap_seq_detector
// Counter checks are active when MOORE_OVER_COUNT_EN is defined.
module tb_moore_overlap_seq_detector;
  logic clk = 1'b0;
  logic rst;
  logic data;
  logic detector;
`ifdef MOORE_OVER_COUNT_EN
  logic [7:0] match_count;
`endif

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic exp_q[$];
  logic [3:0] hist;
  int nbits;
  int exp_count;
  int pulses;

  always #5 clk = ~clk;

  moore_overlap_seq_detector dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .detector(detector)
`ifdef MOORE_OVER_COUNT_EN
    , .match_count(match_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = 4'b0000;
    nbits = 0;
    exp_count = 0;
  endtask

  // Reference: a match is the last four bits since reset reading 1,0,0,1.
  task automatic drive(input logic b, input string tag);
    logic e;
    hist = {hist[2:0], b};
    nbits++;
    e = (nbits >= 4) && (hist == 4'b1001);
    exp_q.push_back(e);
    if (e && exp_count < 255) exp_count++;
    data = b;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {31'd0, detector}, {31'd0, e});
      if (detector === 1'b1) pulses++;
    end
`ifdef MOORE_OVER_COUNT_EN
    check({tag, "_count"}, {24'd0, match_count}, exp_count);
`endif
  endtask

  initial begin
    logic [16:0] stream;
    rst = 1'b1;
    data = 1'b0;
    model_reset();
    #1;
    check("reset_det_t0", {31'd0, detector}, 32'd0);
    check("reset_state_t0", {29'd0, dut.state}, 32'd0);
    // data toggles while reset is held across two edges
    for (int i = 0; i < 4; i++) begin
      data = ~data;
      #3;
      check("reset_det_hold", {31'd0, detector}, 32'd0);
      check("reset_state_hold", {29'd0, dut.state}, 32'd0);
    end
`ifdef MOORE_OVER_COUNT_EN
    check("reset_count", {24'd0, match_count}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic match then one trailing 0
    pulses = 0;
    drive(1'b1, "basic_b1");
    drive(1'b0, "basic_b2");
    drive(1'b0, "basic_b3");
    drive(1'b1, "basic_b4");
    check("basic_pulse_seen", {31'd0, detector}, 32'd1);
    drive(1'b0, "basic_b5");
    check("basic_pulse_done", {31'd0, detector}, 32'd0);

    // overlap stream with four expected pulses
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    pulses = 0;
    stream = 17'b10100100100111001;
    for (int i = 16; i >= 0; i--) drive(stream[i], "overlap");
    check("overlap_pulses", pulses, 32'd4);
`ifdef MOORE_OVER_COUNT_EN
    check("overlap_count", {24'd0, match_count}, 32'd4);
`endif

    // non-matching patterns
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, "ones");
    check("ones_state_s1", {29'd0, dut.state}, 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, "zeros");
    for (int i = 0; i < 4; i++) drive(logic'(i % 2 == 0), "alt");
    check("nonmatch_pulses", pulses, 32'd0);

    // reset in the middle of a pattern
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    drive(1'b1, "mid_b1");
    drive(1'b0, "mid_b2");
    drive(1'b0, "mid_b3");
    check("mid_state_s3", {29'd0, dut.state}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_state_async", {29'd0, dut.state}, 32'd0);
    check("mid_det_async", {31'd0, detector}, 32'd0);
    rst = 1'b0;
    model_reset();
    drive(1'b1, "mid_after");
    check("mid_state_s1", {29'd0, dut.state}, 32'd1);
    drive(1'b0, "mid_c2");
    drive(1'b0, "mid_c3");
    drive(1'b1, "mid_c4");
    check("mid_detect", {31'd0, detector}, 32'd1);

`ifdef MOORE_OVER_COUNT_EN
    // saturation: back-to-back overlapped matches past the counter limit
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    drive(1'b1, "sat_lead");
    for (int m = 0; m < 260; m++) begin
      drive(1'b0, "sat");
      drive(1'b0, "sat");
      drive(1'b1, "sat");
    end
    check("sat_final", {24'd0, match_count}, 32'd255);
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
